regfile: RTL and testbench
==========================

Name: regfile

Overview:
- 32 x 32-bit general-purpose register file for the MIPS datapath (decode stage).
- Two combinational read ports (rd1/rd2) and one synchronous write port (port 3).
- Register 0 is hardwired to zero, per MIPS $zero semantics.
- Synchronous active-high reset clears the whole array.

Parameters:
- WORD_LEN, 32, data width of each register and of the read/write data ports
- ADDR_LEN, 5, width of every register address port
- NUM_REGS, 32, number of registers (2**ADDR_LEN)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous active-high reset
- we3  input  1  write enable for write port 3
- ra1  input  ADDR_LEN  read address, port 1
- ra2  input  ADDR_LEN  read address, port 2
- wa3  input  ADDR_LEN  write address, port 3
- wd3  input  WORD_LEN  write data, port 3
- rd1  output  WORD_LEN  read data, port 1 (combinational)
- rd2  output  WORD_LEN  read data, port 2 (combinational)

Interface decision: one clock; reset is synchronous and active-high (ports clk and rst).

Behaviour:
- Reset: on a rising clk edge with rst=1, all NUM_REGS registers become 0.
  - Reset has priority over a simultaneous write; the write is dropped.
  - After reset, rd1 = rd2 = 0 for every address.
- Write: on a rising clk edge with rst=0 and we3=1, reg[wa3] <= wd3.
  - The new value is visible on the read ports immediately after that edge (write latency 1 edge).
  - we3=0: no register changes.
- Writes to address 0 are ignored; reg[0] always reads 0.
- Read: rd1 = reg[ra1] and rd2 = reg[ra2], purely combinational, no clock latency.
  - Both ports may address the same register, including 0, and both return the same value.
- Same-cycle read of the address being written (bypass disabled): the read port returns the old value until the edge, then the new value.
- Inputs are sampled only at the rising edge; glitches between edges do not affect stored state.
- All addresses 0..NUM_REGS-1 are valid; no wrap-around or out-of-range handling is needed.
- No X propagation after reset: every register has a defined value.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding on both read ports. When we3=1, rst=0, wa3!=0 and raN==wa3, rdN = wd3 combinationally in the same cycle, before the edge. Otherwise normal read.
- Not defined: no forwarding; reads always return the stored array contents, as described in Behaviour.

Test Plan:
- Reset: assert rst for 1 edge after arbitrary writes -> rd1 = rd2 = 0 for every address 0..31.
- Write/read reg 5: wa3=5, wd3=0xA5A5A5A5, we3=1 for one edge; then we3=0, ra1=5 -> rd1 = 0xA5A5A5A5.
- Separate registers: additionally write reg 3 = 0x3C3C3C3C; then ra1=3, ra2=5 -> rd1 = 0x3C3C3C3C and rd2 = 0xA5A5A5A5 (reg 5 unchanged).
- Register 0: we3=1, wa3=0, wd3=0xFFFFFFFF for one edge; ra1=ra2=0 -> both 0.
- Write disabled: we3=0, wa3=7, wd3=0x12345678 for one edge -> ra1=7 reads 0.
- Reset vs write priority: rst=1 and we3=1, wa3=9, wd3=0xDEADBEEF on the same edge -> reg 9 reads 0.
- Bypass: write wa3=4, wd3=0x0BADF00D with ra1=4, checked before the edge. Without REGFILE_BYPASS_EN, rd1 shows the old value (0). With it, rd1 = 0x0BADF00D. After the edge, both builds read 0x0BADF00D.

Source files
------------

// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one synchronous write port, $zero hardwired.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-through forwarding on both read ports.
module regfile #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we3,
  input  logic [ADDR_LEN-1:0] ra1,
  input  logic [ADDR_LEN-1:0] ra2,
  input  logic [ADDR_LEN-1:0] wa3,
  input  logic [WORD_LEN-1:0] wd3,
  output logic [WORD_LEN-1:0] rd1,
  output logic [WORD_LEN-1:0] rd2
);

  logic [WORD_LEN-1:0] regs_q [NUM_REGS];
  logic [WORD_LEN-1:0] regs_d [NUM_REGS];
  logic                wr_en;

  // Writes to $zero are dropped here, so regs_q[0] never leaves its reset value.
  assign wr_en = we3 && (wa3 != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wa3] = wd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Forward only a write that will actually land on the coming edge.
  assign fwd1 = wr_en && !rst && (ra1 == wa3);
  assign fwd2 = wr_en && !rst && (ra2 == wa3);

  assign rd1 = fwd1 ? wd3 : regs_q[ra1];
  assign rd2 = fwd2 ? wd3 : regs_q[ra2];
`else
  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
`endif

endmodule

// File: tb/tb_regfile.sv
// Directed and randomized checks of regfile against an array-based reference model.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  logic [31:0] model [32];
  int          vectors;
  int          miscompares;

  regfile dut (
    .clk (clk),
    .rst (rst),
    .we3 (we3),
    .ra1 (ra1),
    .ra2 (ra2),
    .wa3 (wa3),
    .wd3 (wd3),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
`ifdef REGFILE_BYPASS_EN
    if (we3 && !rst && wa3 != 0 && addr == wa3) return wd3;
`endif
    return model[addr];
  endfunction

  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we3 && wa3 != 0) begin
      model[wa3] = wd3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    logic [31:0] e1;
    logic [31:0] e2;
    #1;
    e1 = exp_read(ra1);
    e2 = exp_read(ra2);
    vectors++;
    assert (rd1 === e1) else begin
      miscompares++;
      $error("FAIL %s rd1 ra1=%0d got=%h exp=%h", tag, ra1, rd1, e1);
    end
    vectors++;
    assert (rd2 === e2) else begin
      miscompares++;
      $error("FAIL %s rd2 ra2=%0d got=%h exp=%h", tag, ra2, rd2, e2);
    end
  endtask

  task automatic check_const(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scan_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      check(tag);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
    #1;
    tick();
    rst = 1'b0;
    scan_all("reset_initial");

    // arbitrary writes, then reset must clear everything
    for (int n = 0; n < 40; n++) begin
      we3 = 1'b1;
      wa3 = 5'($urandom_range(0, 31));
      wd3 = $urandom;
      tick();
    end
    we3 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    scan_all("reset_after_writes");

    // write/read reg 5
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hA5A5A5A5;
    tick();
    we3 = 1'b0; ra1 = 5'd5; ra2 = 5'd0;
    #1;
    check_const("reg5_rd1", rd1, 32'hA5A5A5A5);

    // separate registers
    we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h3C3C3C3C;
    tick();
    we3 = 1'b0; ra1 = 5'd3; ra2 = 5'd5;
    #1;
    check_const("reg3_rd1", rd1, 32'h3C3C3C3C);
    check_const("reg5_rd2", rd2, 32'hA5A5A5A5);

    // register 0 ignores writes
    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFFFFFF;
    tick();
    we3 = 1'b0; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    check_const("reg0_rd1", rd1, 32'h0);
    check_const("reg0_rd2", rd2, 32'h0);

    // write disabled
    we3 = 1'b0; wa3 = 5'd7; wd3 = 32'h12345678;
    tick();
    ra1 = 5'd7;
    #1;
    check_const("we_off_reg7", rd1, 32'h0);

    // reset beats write on the same edge
    rst = 1'b1; we3 = 1'b1; wa3 = 5'd9; wd3 = 32'hDEADBEEF;
    tick();
    rst = 1'b0; we3 = 1'b0; ra1 = 5'd9; ra2 = 5'd5;
    #1;
    check_const("rst_prio_reg9", rd1, 32'h0);
    check_const("rst_clears_reg5", rd2, 32'h0);

    // same-cycle read of the address being written
    we3 = 1'b1; wa3 = 5'd4; wd3 = 32'h0BADF00D; ra1 = 5'd4; ra2 = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_const("bypass_pre_edge", rd1, 32'h0BADF00D);
`else
    check_const("bypass_pre_edge", rd1, 32'h0);
`endif
    tick();
    we3 = 1'b0;
    #1;
    check_const("bypass_post_edge_rd1", rd1, 32'h0BADF00D);
    check_const("bypass_post_edge_rd2", rd2, 32'h0BADF00D);

    // randomized traffic, checked both before and after each edge
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      we3 = ($urandom_range(0, 3) != 0);
      wa3 = 5'($urandom_range(0, 31));
      wd3 = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
      check("rand_pre_edge");
      tick();
      check("rand_post_edge");
    end
    rst = 1'b0; we3 = 1'b0;
    scan_all("final_scan");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
